// File: rtl/axi_protocol_checker_if.sv
// Observed AXI3/AXI4 port bundle (all five channels) shared by the bus agents and the passive checker.
interface axi_protocol_checker_if #(
  parameter int unsigned C_AXI_ID_WIDTH   = 8,
  parameter int unsigned C_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_AXI_DATA_WIDTH = 64,
  parameter int unsigned C_AXI_LEN_WIDTH  = 4
);
  localparam int unsigned STRB_W = C_AXI_DATA_WIDTH / 8;

  logic [C_AXI_ID_WIDTH-1:0]   AXI_AWID;
  logic [C_AXI_ADDR_WIDTH-1:0] AXI_AWADDR;
  logic [C_AXI_LEN_WIDTH-1:0]  AXI_AWLEN;
  logic [2:0]                  AXI_AWSIZE;
  logic [1:0]                  AXI_AWBURST;
  logic                        AXI_AWVALID;
  logic                        AXI_AWREADY;

  logic [C_AXI_DATA_WIDTH-1:0] AXI_WDATA;
  logic [STRB_W-1:0]           AXI_WSTRB;
  logic                        AXI_WLAST;
  logic                        AXI_WVALID;
  logic                        AXI_WREADY;

  logic [C_AXI_ID_WIDTH-1:0]   AXI_BID;
  logic [1:0]                  AXI_BRESP;
  logic                        AXI_BVALID;
  logic                        AXI_BREADY;

  logic [C_AXI_ID_WIDTH-1:0]   AXI_ARID;
  logic [C_AXI_ADDR_WIDTH-1:0] AXI_ARADDR;
  logic [C_AXI_LEN_WIDTH-1:0]  AXI_ARLEN;
  logic [2:0]                  AXI_ARSIZE;
  logic [1:0]                  AXI_ARBURST;
  logic                        AXI_ARVALID;
  logic                        AXI_ARREADY;

  logic [C_AXI_ID_WIDTH-1:0]   AXI_RID;
  logic [C_AXI_DATA_WIDTH-1:0] AXI_RDATA;
  logic [1:0]                  AXI_RRESP;
  logic                        AXI_RLAST;
  logic                        AXI_RVALID;
  logic                        AXI_RREADY;

  modport master (
    output AXI_AWID, AXI_AWADDR, AXI_AWLEN, AXI_AWSIZE, AXI_AWBURST, AXI_AWVALID,
    input  AXI_AWREADY,
    output AXI_WDATA, AXI_WSTRB, AXI_WLAST, AXI_WVALID,
    input  AXI_WREADY,
    input  AXI_BID, AXI_BRESP, AXI_BVALID,
    output AXI_BREADY,
    output AXI_ARID, AXI_ARADDR, AXI_ARLEN, AXI_ARSIZE, AXI_ARBURST, AXI_ARVALID,
    input  AXI_ARREADY,
    input  AXI_RID, AXI_RDATA, AXI_RRESP, AXI_RLAST, AXI_RVALID,
    output AXI_RREADY
  );

  modport slave (
    input  AXI_AWID, AXI_AWADDR, AXI_AWLEN, AXI_AWSIZE, AXI_AWBURST, AXI_AWVALID,
    output AXI_AWREADY,
    input  AXI_WDATA, AXI_WSTRB, AXI_WLAST, AXI_WVALID,
    output AXI_WREADY,
    output AXI_BID, AXI_BRESP, AXI_BVALID,
    input  AXI_BREADY,
    input  AXI_ARID, AXI_ARADDR, AXI_ARLEN, AXI_ARSIZE, AXI_ARBURST, AXI_ARVALID,
    output AXI_ARREADY,
    output AXI_RID, AXI_RDATA, AXI_RRESP, AXI_RLAST, AXI_RVALID,
    input  AXI_RREADY
  );

  // Passive observer: sees every signal, drives none.
  modport monitor (
    input AXI_AWID, AXI_AWADDR, AXI_AWLEN, AXI_AWSIZE, AXI_AWBURST, AXI_AWVALID, AXI_AWREADY,
    input AXI_WDATA, AXI_WSTRB, AXI_WLAST, AXI_WVALID, AXI_WREADY,
    input AXI_BID, AXI_BRESP, AXI_BVALID, AXI_BREADY,
    input AXI_ARID, AXI_ARADDR, AXI_ARLEN, AXI_ARSIZE, AXI_ARBURST, AXI_ARVALID, AXI_ARREADY,
    input AXI_RID, AXI_RDATA, AXI_RRESP, AXI_RLAST, AXI_RVALID, AXI_RREADY
  );
endinterface

// File: rtl/axi_protocol_checker.sv
// Passive AXI3/AXI4 protocol checker: stability, burst length, response bookkeeping, sticky error status.
// Define AXI_CHK_RLEN_EN to add in-order ARLEN tracking and the RLAST length check (code 13).
module axi_protocol_checker #(
  parameter int unsigned C_AXI_ID_WIDTH    = 8,
  parameter int unsigned C_AXI_ADDR_WIDTH  = 32,
  parameter int unsigned C_AXI_DATA_WIDTH  = 64,
  parameter int unsigned C_AXI_LEN_WIDTH   = 4,
  parameter int unsigned C_MAX_OUTSTANDING = 8,
  parameter int unsigned C_ERRCNT_WIDTH    = 16
) (
  input  logic                                 AXI_ACLK,
  input  logic                                 AXI_ARESET,
  input  logic                                 chk_en,
  input  logic                                 err_clr,
  axi_protocol_checker_if.monitor              axi,
  output logic                                 err_valid,
  output logic [3:0]                           err_code,
  output logic [15:0]                          err_status,
  output logic [C_ERRCNT_WIDTH-1:0]            err_count,
  output logic [$clog2(C_MAX_OUTSTANDING):0]   wr_outstanding,
  output logic [$clog2(C_MAX_OUTSTANDING):0]   rd_outstanding
);
  localparam int unsigned PTR_W  = $clog2(C_MAX_OUTSTANDING);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned LEN_W  = C_AXI_LEN_WIDTH;
  localparam int unsigned STRB_W = C_AXI_DATA_WIDTH / 8;
  localparam int unsigned AX_PW  = C_AXI_ID_WIDTH + C_AXI_ADDR_WIDTH + LEN_W + 3 + 2;
  localparam int unsigned W_PW   = C_AXI_DATA_WIDTH + STRB_W + 1;
  localparam int unsigned B_PW   = C_AXI_ID_WIDTH + 2;
  localparam int unsigned R_PW   = C_AXI_ID_WIDTH + C_AXI_DATA_WIDTH + 2 + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(C_MAX_OUTSTANDING);

  // Channel payloads: everything except VALID/READY.
  logic [AX_PW-1:0] aw_pl, ar_pl, aw_pl_q, ar_pl_q;
  logic [W_PW-1:0]  w_pl, w_pl_q;
  logic [B_PW-1:0]  b_pl, b_pl_q;
  logic [R_PW-1:0]  r_pl, r_pl_q;
  logic aw_vld_q, aw_rdy_q, w_vld_q, w_rdy_q, b_vld_q, b_rdy_q;
  logic ar_vld_q, ar_rdy_q, r_vld_q, r_rdy_q;

  assign aw_pl = {axi.AXI_AWID, axi.AXI_AWADDR, axi.AXI_AWLEN, axi.AXI_AWSIZE, axi.AXI_AWBURST};
  assign ar_pl = {axi.AXI_ARID, axi.AXI_ARADDR, axi.AXI_ARLEN, axi.AXI_ARSIZE, axi.AXI_ARBURST};
  assign w_pl  = {axi.AXI_WDATA, axi.AXI_WSTRB, axi.AXI_WLAST};
  assign b_pl  = {axi.AXI_BID, axi.AXI_BRESP};
  assign r_pl  = {axi.AXI_RID, axi.AXI_RDATA, axi.AXI_RRESP, axi.AXI_RLAST};

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = axi.AXI_AWVALID & axi.AXI_AWREADY;
  assign w_hs  = axi.AXI_WVALID  & axi.AXI_WREADY;
  assign b_hs  = axi.AXI_BVALID  & axi.AXI_BREADY;
  assign ar_hs = axi.AXI_ARVALID & axi.AXI_ARREADY;
  assign r_hs  = axi.AXI_RVALID  & axi.AXI_RREADY;

  // A stalled VALID must stay high with its payload frozen.
  logic aw_unst, w_unst, b_unst, ar_unst, r_unst;
  assign aw_unst = aw_vld_q & ~aw_rdy_q & (~axi.AXI_AWVALID | (aw_pl != aw_pl_q));
  assign w_unst  = w_vld_q  & ~w_rdy_q  & (~axi.AXI_WVALID  | (w_pl  != w_pl_q));
  assign b_unst  = b_vld_q  & ~b_rdy_q  & (~axi.AXI_BVALID  | (b_pl  != b_pl_q));
  assign ar_unst = ar_vld_q & ~ar_rdy_q & (~axi.AXI_ARVALID | (ar_pl != ar_pl_q));
  assign r_unst  = r_vld_q  & ~r_rdy_q  & (~axi.AXI_RVALID  | (r_pl  != r_pl_q));

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      aw_vld_q <= 1'b0; aw_rdy_q <= 1'b0; aw_pl_q <= '0;
      w_vld_q  <= 1'b0; w_rdy_q  <= 1'b0; w_pl_q  <= '0;
      b_vld_q  <= 1'b0; b_rdy_q  <= 1'b0; b_pl_q  <= '0;
      ar_vld_q <= 1'b0; ar_rdy_q <= 1'b0; ar_pl_q <= '0;
      r_vld_q  <= 1'b0; r_rdy_q  <= 1'b0; r_pl_q  <= '0;
    end else begin
      aw_vld_q <= axi.AXI_AWVALID; aw_rdy_q <= axi.AXI_AWREADY; aw_pl_q <= aw_pl;
      w_vld_q  <= axi.AXI_WVALID;  w_rdy_q  <= axi.AXI_WREADY;  w_pl_q  <= w_pl;
      b_vld_q  <= axi.AXI_BVALID;  b_rdy_q  <= axi.AXI_BREADY;  b_pl_q  <= b_pl;
      ar_vld_q <= axi.AXI_ARVALID; ar_rdy_q <= axi.AXI_ARREADY; ar_pl_q <= ar_pl;
      r_vld_q  <= axi.AXI_RVALID;  r_rdy_q  <= axi.AXI_RREADY;  r_pl_q  <= r_pl;
    end
  end

  // Write path: AWLEN FIFO, W beat counter, completed-burst (b_ready) counter.
  logic [LEN_W-1:0] awlen_mem [C_MAX_OUTSTANDING];
  logic [PTR_W-1:0] wf_wr_ptr, wf_rd_ptr;
  logic [CNT_W-1:0] wf_cnt, b_cnt;
  logic [LEN_W-1:0] w_beat, w_beat_d, wf_head;
  logic wf_push, wf_pop, b_inc, b_dec, wr_inc, wr_dec;
  logic v_aw_ovf, v_w_early, v_w_miss, v_w_noaw, v_b_none;

  assign wf_head = awlen_mem[wf_rd_ptr];

  always_comb begin
    wf_push   = 1'b0;
    wf_pop    = 1'b0;
    b_inc     = 1'b0;
    b_dec     = 1'b0;
    wr_inc    = 1'b0;
    wr_dec    = 1'b0;
    w_beat_d  = w_beat;
    v_aw_ovf  = 1'b0;
    v_w_early = 1'b0;
    v_w_miss  = 1'b0;
    v_w_noaw  = 1'b0;
    v_b_none  = 1'b0;
    if (aw_hs) begin
      if (wr_outstanding == MAX_CNT) begin
        v_aw_ovf = 1'b1;
      end else begin
        wr_inc  = 1'b1;
        wf_push = (wf_cnt != MAX_CNT);
      end
    end
    if (w_hs) begin
      if (wf_cnt == '0) begin
        v_w_noaw = 1'b1;
      end else begin
        v_w_early = axi.AXI_WLAST & (w_beat < wf_head);
        v_w_miss  = ~axi.AXI_WLAST & (w_beat == wf_head);
        if (axi.AXI_WLAST || (w_beat == wf_head)) begin
          wf_pop   = 1'b1;
          b_inc    = 1'b1;
          w_beat_d = '0;
        end else begin
          w_beat_d = w_beat + LEN_W'(1);
        end
      end
    end
    if (b_hs) begin
      if (b_cnt == '0) begin
        v_b_none = 1'b1;
      end else begin
        b_dec  = 1'b1;
        wr_dec = 1'b1;
      end
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (wf_push) awlen_mem[wf_wr_ptr] <= axi.AXI_AWLEN;
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      wf_wr_ptr      <= '0;
      wf_rd_ptr      <= '0;
      wf_cnt         <= '0;
      w_beat         <= '0;
      b_cnt          <= '0;
      wr_outstanding <= '0;
    end else begin
      w_beat <= w_beat_d;
      if (wf_push) wf_wr_ptr <= wf_wr_ptr + PTR_W'(1);
      if (wf_pop)  wf_rd_ptr <= wf_rd_ptr + PTR_W'(1);
      case ({wf_push, wf_pop})
        2'b10:   wf_cnt <= wf_cnt + CNT_W'(1);
        2'b01:   wf_cnt <= wf_cnt - CNT_W'(1);
        default: wf_cnt <= wf_cnt;
      endcase
      case ({b_inc, b_dec})
        2'b10:   b_cnt <= b_cnt + CNT_W'(1);
        2'b01:   b_cnt <= b_cnt - CNT_W'(1);
        default: b_cnt <= b_cnt;
      endcase
      case ({wr_inc, wr_dec})
        2'b10:   wr_outstanding <= wr_outstanding + CNT_W'(1);
        2'b01:   wr_outstanding <= wr_outstanding - CNT_W'(1);
        default: wr_outstanding <= wr_outstanding;
      endcase
    end
  end

  // Read path: outstanding count closes on the last R beat.
  logic rd_inc, rd_dec, v_ar_ovf, v_r_none, v_rlen;
  assign v_ar_ovf = ar_hs & (rd_outstanding == MAX_CNT);
  assign rd_inc   = ar_hs & (rd_outstanding != MAX_CNT);
  assign v_r_none = r_hs & (rd_outstanding == '0);
  assign rd_dec   = r_hs & (rd_outstanding != '0) & axi.AXI_RLAST;

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      rd_outstanding <= '0;
    end else begin
      case ({rd_inc, rd_dec})
        2'b10:   rd_outstanding <= rd_outstanding + CNT_W'(1);
        2'b01:   rd_outstanding <= rd_outstanding - CNT_W'(1);
        default: rd_outstanding <= rd_outstanding;
      endcase
    end
  end

`ifdef AXI_CHK_RLEN_EN
  // In-order ARLEN FIFO; RLAST must land exactly on beat == ARLEN.
  logic [LEN_W-1:0] arlen_mem [C_MAX_OUTSTANDING];
  logic [PTR_W-1:0] rf_wr_ptr, rf_rd_ptr;
  logic [CNT_W-1:0] rf_cnt;
  logic [LEN_W-1:0] r_beat, r_beat_d, rf_head;
  logic rf_push, rf_pop;

  assign rf_head = arlen_mem[rf_rd_ptr];
  assign rf_push = rd_inc & (rf_cnt != MAX_CNT);

  always_comb begin
    rf_pop   = 1'b0;
    v_rlen   = 1'b0;
    r_beat_d = r_beat;
    if (r_hs && (rf_cnt != '0)) begin
      v_rlen = axi.AXI_RLAST ^ (r_beat == rf_head);
      if (axi.AXI_RLAST) begin
        rf_pop   = 1'b1;
        r_beat_d = '0;
      end else begin
        r_beat_d = r_beat + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (rf_push) arlen_mem[rf_wr_ptr] <= axi.AXI_ARLEN;
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      rf_wr_ptr <= '0;
      rf_rd_ptr <= '0;
      rf_cnt    <= '0;
      r_beat    <= '0;
    end else begin
      r_beat <= r_beat_d;
      if (rf_push) rf_wr_ptr <= rf_wr_ptr + PTR_W'(1);
      if (rf_pop)  rf_rd_ptr <= rf_rd_ptr + PTR_W'(1);
      case ({rf_push, rf_pop})
        2'b10:   rf_cnt <= rf_cnt + CNT_W'(1);
        2'b01:   rf_cnt <= rf_cnt - CNT_W'(1);
        default: rf_cnt <= rf_cnt;
      endcase
    end
  end
`else
  assign v_rlen = 1'b0;
`endif

  // Violation vector, bit n = code n; lowest set bit wins err_code.
  logic [15:0] viol;
  logic [3:0]  first_code;
  assign viol = {2'b00, v_rlen, v_ar_ovf, v_aw_ovf, v_r_none, v_b_none, v_w_noaw,
                 v_w_miss, v_w_early, r_unst, b_unst, ar_unst, w_unst, aw_unst, 1'b0};

  always_comb begin
    first_code = 4'd0;
    for (int i = 15; i >= 1; i--) begin
      if (viol[i]) first_code = 4'(i);
    end
  end

  logic fire;
  assign fire = chk_en & (viol != '0);

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      err_valid  <= 1'b0;
      err_code   <= '0;
      err_status <= '0;
      err_count  <= '0;
    end else begin
      err_valid <= fire;
      err_code  <= fire ? first_code : 4'd0;
      if (err_clr) begin
        err_status <= '0;
        err_count  <= '0;
      end else if (fire) begin
        err_status <= err_status | viol;
        if (err_count != '1) err_count <= err_count + C_ERRCNT_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_axi_protocol_checker.sv
// Directed self-checking bench for axi_protocol_checker; define AXI_CHK_RLEN_EN to also exercise code 13.
module tb_axi_protocol_checker;
  localparam int unsigned IDW = 8;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 64;
  localparam int unsigned LW  = 4;
  localparam int unsigned MO  = 8;
  localparam int unsigned ECW = 16;

  logic AXI_ACLK   = 1'b0;
  logic AXI_ARESET = 1'b1;
  logic chk_en     = 1'b1;
  logic err_clr    = 1'b0;
  logic           err_valid;
  logic [3:0]     err_code;
  logic [15:0]    err_status;
  logic [ECW-1:0] err_count;
  logic [$clog2(MO):0] wr_outstanding, rd_outstanding;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] dcnt = 64'h0;

  axi_protocol_checker_if #(.C_AXI_ID_WIDTH(IDW), .C_AXI_ADDR_WIDTH(AW),
                            .C_AXI_DATA_WIDTH(DW), .C_AXI_LEN_WIDTH(LW)) bus ();

  axi_protocol_checker #(
    .C_AXI_ID_WIDTH(IDW), .C_AXI_ADDR_WIDTH(AW), .C_AXI_DATA_WIDTH(DW),
    .C_AXI_LEN_WIDTH(LW), .C_MAX_OUTSTANDING(MO), .C_ERRCNT_WIDTH(ECW)
  ) dut (
    .AXI_ACLK(AXI_ACLK), .AXI_ARESET(AXI_ARESET), .chk_en(chk_en), .err_clr(err_clr),
    .axi(bus), .err_valid(err_valid), .err_code(err_code), .err_status(err_status),
    .err_count(err_count), .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding)
  );

  always #5 AXI_ACLK = ~AXI_ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge AXI_ACLK);
    #1;
  endtask

  task automatic clr_bus();
    bus.AXI_AWID = '0; bus.AXI_AWADDR = '0; bus.AXI_AWLEN = '0; bus.AXI_AWSIZE = 3'd3;
    bus.AXI_AWBURST = 2'b01; bus.AXI_AWVALID = 1'b0; bus.AXI_AWREADY = 1'b0;
    bus.AXI_WDATA = '0; bus.AXI_WSTRB = '1; bus.AXI_WLAST = 1'b0;
    bus.AXI_WVALID = 1'b0; bus.AXI_WREADY = 1'b0;
    bus.AXI_BID = '0; bus.AXI_BRESP = '0; bus.AXI_BVALID = 1'b0; bus.AXI_BREADY = 1'b0;
    bus.AXI_ARID = '0; bus.AXI_ARADDR = '0; bus.AXI_ARLEN = '0; bus.AXI_ARSIZE = 3'd3;
    bus.AXI_ARBURST = 2'b01; bus.AXI_ARVALID = 1'b0; bus.AXI_ARREADY = 1'b0;
    bus.AXI_RID = '0; bus.AXI_RDATA = '0; bus.AXI_RRESP = '0; bus.AXI_RLAST = 1'b0;
    bus.AXI_RVALID = 1'b0; bus.AXI_RREADY = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic do_aw(input logic [LW-1:0] len, input logic [AW-1:0] addr);
    clr_bus();
    bus.AXI_AWLEN = len; bus.AXI_AWADDR = addr;
    bus.AXI_AWVALID = 1'b1; bus.AXI_AWREADY = 1'b1;
    tick();
  endtask

  task automatic do_w(input logic last);
    clr_bus();
    dcnt = dcnt + 64'h1;
    bus.AXI_WDATA = dcnt; bus.AXI_WLAST = last;
    bus.AXI_WVALID = 1'b1; bus.AXI_WREADY = 1'b1;
    tick();
  endtask

  task automatic do_b();
    clr_bus();
    bus.AXI_BVALID = 1'b1; bus.AXI_BREADY = 1'b1;
    tick();
  endtask

  task automatic do_ar(input logic [LW-1:0] len, input logic [AW-1:0] addr);
    clr_bus();
    bus.AXI_ARLEN = len; bus.AXI_ARADDR = addr;
    bus.AXI_ARVALID = 1'b1; bus.AXI_ARREADY = 1'b1;
    tick();
  endtask

  task automatic do_r(input logic last);
    clr_bus();
    dcnt = dcnt + 64'h1;
    bus.AXI_RDATA = dcnt; bus.AXI_RLAST = last;
    bus.AXI_RVALID = 1'b1; bus.AXI_RREADY = 1'b1;
    tick();
  endtask

  task automatic do_clr();
    clr_bus();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    // Reset state
    clr_bus();
    AXI_ARESET = 1'b1;
    tick(); tick();
    chk("rst_err_valid", 32'(err_valid), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_err_status", 32'(err_status), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_wr_out", 32'(wr_outstanding), 32'd0);
    chk("rst_rd_out", 32'(rd_outstanding), 32'd0);
    AXI_ARESET = 1'b0;

    // Clean 4-beat write burst
    do_aw(4'd3, 32'h100);
    chk("t1_aw_wr_out", 32'(wr_outstanding), 32'd1);
    for (int i = 0; i < 3; i++) begin
      do_w(1'b0);
      chk("t1_w_err", 32'(err_valid), 32'd0);
    end
    do_w(1'b1);
    chk("t1_wlast_err", 32'(err_valid), 32'd0);
    chk("t1_wlast_wr_out", 32'(wr_outstanding), 32'd1);
    do_b();
    chk("t1_b_err", 32'(err_valid), 32'd0);
    chk("t1_b_wr_out", 32'(wr_outstanding), 32'd0);

    // AW payload change while stalled
    clr_bus();
    bus.AXI_AWVALID = 1'b1; bus.AXI_AWADDR = 32'h1000;
    tick();
    chk("t2_stall_err", 32'(err_valid), 32'd0);
    bus.AXI_AWADDR = 32'h1004;
    tick();
    chk("t2_unst_valid", 32'(err_valid), 32'd1);
    chk("t2_unst_code", 32'(err_code), 32'd1);
    chk("t2_unst_status", 32'(err_status), 32'h0002);
    chk("t2_unst_count", 32'(err_count), 32'd1);
    bus.AXI_AWREADY = 1'b1;
    tick();
    chk("t2_accept_err", 32'(err_valid), 32'd0);
    chk("t2_accept_wr_out", 32'(wr_outstanding), 32'd1);
    do_w(1'b1);
    chk("t2_w_err", 32'(err_valid), 32'd0);
    do_b();
    chk("t2_b_wr_out", 32'(wr_outstanding), 32'd0);
    do_clr();
    chk("t2_clr_status", 32'(err_status), 32'd0);
    chk("t2_clr_count", 32'(err_count), 32'd0);

    // WLAST early then WLAST missing
    do_aw(4'd3, 32'h200);
    do_w(1'b0);
    chk("t3_beat1_err", 32'(err_valid), 32'd0);
    do_w(1'b1);
    chk("t3_early_valid", 32'(err_valid), 32'd1);
    chk("t3_early_code", 32'(err_code), 32'd6);
    do_b();
    chk("t3_b1_err", 32'(err_valid), 32'd0);
    do_aw(4'd1, 32'h300);
    do_w(1'b0);
    chk("t3_beat1b_err", 32'(err_valid), 32'd0);
    do_w(1'b0);
    chk("t3_miss_code", 32'(err_code), 32'd7);
    do_b();
    chk("t3_b2_wr_out", 32'(wr_outstanding), 32'd0);
    chk("t3_status", 32'(err_status), 32'h00C0);
    chk("t3_count", 32'(err_count), 32'd2);
    do_clr();

    // Orphan W and orphan B
    do_w(1'b1);
    chk("t4_noaw_code", 32'(err_code), 32'd8);
    do_b();
    chk("t4_nob_code", 32'(err_code), 32'd9);
    chk("t4_count", 32'(err_count), 32'd2);
    chk("t4_status", 32'(err_status), 32'h0300);
    chk("t4_wr_out", 32'(wr_outstanding), 32'd0);
    do_clr();
    chk("t4_clr_status", 32'(err_status), 32'd0);
    chk("t4_clr_count", 32'(err_count), 32'd0);

    // Checks masked
    chk_en = 1'b0;
    do_w(1'b1);
    chk("t5_mask_valid", 32'(err_valid), 32'd0);
    chk("t5_mask_status", 32'(err_status), 32'd0);
    chk_en = 1'b1;

    // AR overflow, drain, orphan R
    for (int i = 0; i < 8; i++) do_ar(4'd0, 32'(i * 16));
    chk("t6_full_rd_out", 32'(rd_outstanding), 32'd8);
    chk("t6_full_err", 32'(err_valid), 32'd0);
    do_ar(4'd0, 32'h900);
    chk("t6_ovf_valid", 32'(err_valid), 32'd1);
    chk("t6_ovf_code", 32'(err_code), 32'd12);
    chk("t6_ovf_rd_out", 32'(rd_outstanding), 32'd8);
    for (int i = 0; i < 8; i++) do_r(1'b1);
    chk("t6_drain_rd_out", 32'(rd_outstanding), 32'd0);
    chk("t6_drain_err", 32'(err_valid), 32'd0);
    do_r(1'b1);
    chk("t6_nor_code", 32'(err_code), 32'd10);
    chk("t6_status", 32'(err_status), 32'h1400);

`ifdef AXI_CHK_RLEN_EN
    // RLAST on the second beat of a 3-beat read
    do_ar(4'd2, 32'hA00);
    chk("t7_rd_out", 32'(rd_outstanding), 32'd1);
    do_r(1'b0);
    chk("t7_beat1_err", 32'(err_valid), 32'd0);
    do_r(1'b1);
    chk("t7_rlen_code", 32'(err_code), 32'd13);
    chk("t7_rd_out_end", 32'(rd_outstanding), 32'd0);
`endif

    // Reset mid-burst, then a clean burst
    do_aw(4'd3, 32'hB00);
    do_w(1'b0);
    do_w(1'b0);
    chk("t8_mid_wr_out", 32'(wr_outstanding), 32'd1);
    clr_bus();
    AXI_ARESET = 1'b1;
    tick();
    chk("t8_rst_valid", 32'(err_valid), 32'd0);
    chk("t8_rst_code", 32'(err_code), 32'd0);
    chk("t8_rst_status", 32'(err_status), 32'd0);
    chk("t8_rst_count", 32'(err_count), 32'd0);
    chk("t8_rst_wr_out", 32'(wr_outstanding), 32'd0);
    chk("t8_rst_rd_out", 32'(rd_outstanding), 32'd0);
    AXI_ARESET = 1'b0;
    do_aw(4'd1, 32'hC00);
    chk("t8_aw_wr_out", 32'(wr_outstanding), 32'd1);
    do_w(1'b0);
    chk("t8_w1_err", 32'(err_valid), 32'd0);
    do_w(1'b1);
    chk("t8_w2_err", 32'(err_valid), 32'd0);
    do_b();
    chk("t8_b_err", 32'(err_valid), 32'd0);
    chk("t8_b_wr_out", 32'(wr_outstanding), 32'd0);
    chk("t8_count", 32'(err_count), 32'd0);

    clr_bus();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axi_protocol_checker.md
Name: axi_protocol_checker

Overview:
- Synthesizable, passive AXI3/AXI4 protocol checker that observes one master/slave port and reports violations as registered error codes.
- Successor to the assertion-only master interface checks. Adds:
  - parametrised widths and outstanding depth
  - VALID/payload stability checks on all five channels
  - write burst beat counting against AWLEN
  - response bookkeeping
  - sticky error status
- Sits beside the DUT in the env top and in emulation builds. Never drives the bus.

Parameters:
- C_AXI_ID_WIDTH, 8, width of AWID/WID/BID/ARID/RID
- C_AXI_ADDR_WIDTH, 32, address width
- C_AXI_DATA_WIDTH, 64, WDATA/RDATA width
- C_AXI_LEN_WIDTH, 4, AWLEN/ARLEN width (4 = AXI3, 8 = AXI4)
- C_MAX_OUTSTANDING, 8, depth of the AW length FIFO and the limit of all outstanding counters; power of two, at least 2
- C_ERRCNT_WIDTH, 16, width of the error counter

Ports:
- AXI_ACLK  in  1  single clock
- AXI_ARESET  in  1  synchronous, active-high reset
- chk_en  in  1  1 = checks active; 0 = error reporting masked, bookkeeping still runs
- err_clr  in  1  single-cycle pulse that clears err_status and err_count
- AXI_AW{ID,ADDR,LEN,SIZE,BURST,VALID,READY}  in  per parameters  observed write address channel
- AXI_W{DATA,STRB,LAST,VALID,READY}  in  per parameters  observed write data channel; WSTRB width is C_AXI_DATA_WIDTH/8
- AXI_B{ID,RESP,VALID,READY}  in  per parameters  observed write response channel
- AXI_AR{ID,ADDR,LEN,SIZE,BURST,VALID,READY}  in  per parameters  observed read address channel
- AXI_R{ID,DATA,RESP,LAST,VALID,READY}  in  per parameters  observed read data channel
- err_valid  out  1  one-cycle pulse, asserted when any enabled check fires
- err_code  out  4  code of the highest-priority (lowest-numbered) violation that cycle
- err_status  out  16  sticky bit per code; bit[n] is set by code n
- err_count  out  C_ERRCNT_WIDTH  number of err_valid pulses, saturating
- wr_outstanding  out  $clog2(C_MAX_OUTSTANDING)+1  number of AWs accepted whose B has not yet been accepted
- rd_outstanding  out  $clog2(C_MAX_OUTSTANDING)+1  number of ARs accepted whose last R beat has not yet been accepted

Behaviour:
- Handshake = VALID & READY sampled at posedge AXI_ACLK.
- Reset:
  - All outputs are 0; the FIFO is empty; the beat counter is 0.
  - Reset asserted mid-burst discards all tracking. No error is reported for the abandoned burst.
- Latency: violations are detected at the sampling edge and reported on the next edge (1-cycle registered). err_status and err_count update in the same cycle as err_valid.
- Error codes:
  - 1: AW stability. Covers AWVALID dropping without READY, or AW payload changing while VALID=1 and READY=0.
  - 2: W stability.
  - 3: AR stability.
  - 4: B stability.
  - 5: R stability.
  - 6: WLAST early (WLAST=1 and beat count < AWLEN).
  - 7: WLAST missing (beat count == AWLEN and WLAST=0).
  - 8: W beat with no pending AW.
  - 9: B with no completed write burst.
  - 10: R with rd_outstanding == 0.
  - 11: AW accepted while wr_outstanding == C_MAX_OUTSTANDING.
  - 12: AR accepted while rd_outstanding == C_MAX_OUTSTANDING.
  - 13: RLAST length mismatch (optional feature only).
  - Codes 0, 14 and 15 are unused.
- Stability checks use registered copies of the previous VALID, READY and payload of each channel. The payload compared on a channel is every signal on that channel other than its VALID and READY.
- Write path:
  - An AW handshake pushes AWLEN into the FIFO and increments wr_outstanding.
  - On a W handshake:
    - FIFO empty: raise code 8; the beat is not counted.
    - Otherwise, compare the beat counter with the FIFO head and raise code 6 or 7 on mismatch.
    - The burst ends when WLAST=1 or beat == head, whichever comes first. At burst end: pop the FIFO, zero the beat counter, and increment the b_ready counter. Otherwise increment the beat counter.
  - AW push and W pop in the same cycle are both honoured. If the FIFO was empty, the simultaneous W still raises code 8; W must follow or coincide-after AW.
- B handshake:
  - b_ready == 0: raise code 9.
  - Otherwise decrement b_ready and wr_outstanding.
- Read path:
  - An AR handshake increments rd_outstanding.
  - An R handshake with RLAST=1 decrements it.
  - Increment and decrement in the same cycle leave the count unchanged.
  - Overflow (codes 11/12): the counter holds at the maximum and the FIFO push is dropped.
- Multiple violations in one cycle: all corresponding err_status bits are set; err_code takes the lowest-numbered code; err_count increments by 1.
- err_clr has priority over setting in the same cycle.
- chk_en=0: err_valid, err_status and err_count are frozen; counters and the FIFO keep tracking.

Optional Feature:
- Macro: AXI_CHK_RLEN_EN.
- Defined:
  - A second FIFO of depth C_MAX_OUTSTANDING stores ARLEN, and an R beat counter is added. Responses are assumed to be in order.
  - RLAST must coincide with beat == ARLEN; otherwise raise code 13.
  - The burst is popped on RLAST.
- Undefined: no ARLEN storage; code 13 is never raised; only the rd_outstanding accounting applies.

Test Plan:
- AW with AWLEN=3 accepted, then 4 W beats with WLAST on beat 4, then B → err_valid never set; wr_outstanding goes 1→1→0.
- AWVALID=1 with AWADDR=0x1000, READY=0; next cycle AWADDR=0x1004 → err_valid one cycle later, err_code=1, err_status=0x0002.
- AWLEN=3 with WLAST on beat 2 → err_code=6. Next AWLEN=1 with 2 beats and no WLAST → err_code=7.
- W beat with no prior AW and BVALID/BREADY with no write → codes 8 and 9 each raised; err_count=2. err_clr → err_status=0, err_count=0.
- 9 ARs accepted with C_MAX_OUTSTANDING=8 → code 12 and rd_outstanding=8. Then R beat with RLAST while rd_outstanding is 0 after drain → code 10.
- AXI_CHK_RLEN_EN defined: ARLEN=2, RLAST on beat 2 → code 13. Reset asserted mid-burst → all outputs 0 on the next cycle, and the next clean burst raises no error.
